// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX stage and the divider.
//   master modport: the EX-side issuer. It drives the request and observes the
//                   result, ready and busy signals.
//   slave  modport: the divider itself.
//   Signals:
//     start_i     request pulse
//     op_i        funct3 (100 DIV, 101 DIVU, 110 REM, 111 REMU)
//     dividend_i  rs1 operand
//     divisor_i   rs2 operand
//     reg_waddr_i destination register
//     result_o    quotient or remainder
//     ready_o     one-cycle completion pulse
//     busy_o      pipeline hold request
//     reg_waddr_o latched destination register for write-back
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [4:0]      reg_waddr_i;
    logic [XLEN-1:0] result_o;
    logic            ready_o;
    logic            busy_o;
    logic [4:0]      reg_waddr_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        input  result_o, ready_o, busy_o, reg_waddr_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        output result_o, ready_o, busy_o, reg_waddr_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divide engine (DIV/DIVU/REM/REMU).
//   The FSM sequences IDLE -> START -> CALC (XLEN restoring steps) -> END.
//   Divide-by-zero and signed overflow bypass CALC.
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  div_unit_if.slave: request in, result/ready/busy/reg_waddr out
module div_unit #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

    state_t state, state_nxt;

    logic             accept;
    logic [1:0]       op_q;      // bit1: remainder wanted, bit0: unsigned
    logic [XLEN-1:0]  dvd_q;     // raw dividend, consumed in START
    logic [XLEN-1:0]  dvs_q;     // raw divisor, replaced by |divisor| in START
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;     // dividend bits shift out as quotient bits shift in
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [XLEN-1:0]  res_q;
    logic [4:0]       waddr_q;

    logic             is_signed;
    logic             div_zero;
    logic             overflow;
    logic             last_step;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic             ge;
    logic [XLEN-1:0]  rem_nxt;
    logic [XLEN-1:0]  quo_nxt;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;

    assign accept    = bus.start_i & bus.op_i[2] & (state == S_IDLE);
    assign is_signed = ~op_q[0];
    assign div_zero  = (dvs_q == '0);
    assign overflow  = is_signed && (dvd_q == {1'b1, {(XLEN-1){1'b0}}}) && (dvs_q == '1);
    assign last_step = (cnt_q == CNT_W'(XLEN-1));

    // One restoring step. The subtract is one bit wider than the operands, so
    // its MSB acts as the borrow and tells whether the divisor fits.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = ~diff[XLEN];
        rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], ge};
        quo_fix = neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
        rem_fix = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: state_nxt = (div_zero || overflow) ? S_END : S_CALC;
            S_CALC:  if (last_step) state_nxt = S_END;
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic. busy_o also covers the accept cycle, so the pipeline holds
    // before the request has even been latched.
    always_comb begin
        bus.busy_o  = (state != S_IDLE) | accept;
        bus.ready_o = (state == S_END);
    end

    assign bus.result_o    = res_q;
    assign bus.reg_waddr_o = waddr_q;

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            waddr_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q    <= bus.op_i[1:0];
                    dvd_q   <= bus.dividend_i;
                    dvs_q   <= bus.divisor_i;
                    waddr_q <= bus.reg_waddr_i;
                end
                S_START: begin
                    if (div_zero) begin
                        res_q <= op_q[1] ? dvd_q : '1;
                    end else if (overflow) begin
                        res_q <= op_q[1] ? '0 : dvd_q;
                    end else begin
                        neg_quo_q <= is_signed & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                        neg_rem_q <= is_signed & dvd_q[XLEN-1];
                        quo_q     <= (is_signed && dvd_q[XLEN-1]) ? (~dvd_q + 1'b1) : dvd_q;
                        dvs_q     <= (is_signed && dvs_q[XLEN-1]) ? (~dvs_q + 1'b1) : dvs_q;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) res_q <= op_q[1] ? rem_fix : quo_fix;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge. Issues the request in this cycle (cycle 0),
    // waits for ready_o and checks latency, busy, result and write-back address.
    // Returns just after the rising edge that ends the END cycle, which is the
    // first IDLE cycle, so another call issues back-to-back.
    // pulse_at >= 0 injects an extra start_i (with different operands) at that cycle.
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat, input int pulse_at);
        int lat;
        int busy_drop;
        lat = -1;
        busy_drop = 0;
        bus.start_i     = 1'b1;
        bus.op_i        = op;
        bus.dividend_i  = a;
        bus.divisor_i   = b;
        bus.reg_waddr_i = rd;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) chk({tag, " rdy0"}, {31'd0, bus.ready_o}, 32'd0);
            if (!bus.busy_o) busy_drop++;
            if (bus.ready_o) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
            bus.start_i     = (c + 1 == pulse_at);
            bus.op_i        = DIV;
            bus.dividend_i  = 32'd1000;
            bus.divisor_i   = 32'd3;
            bus.reg_waddr_i = 5'd31;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, busy_drop, 32'd0);
        chk({tag, " result"}, bus.result_o, exp);
        chk({tag, " rd"}, {27'd0, bus.reg_waddr_o}, {27'd0, rd});
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.op_i        = 3'b000;
        bus.dividend_i  = '0;
        bus.divisor_i   = '0;
        bus.reg_waddr_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset result", bus.result_o, 32'd0);
        chk("reset ready", {31'd0, bus.ready_o}, 32'd0);
        chk("reset busy", {31'd0, bus.busy_o}, 32'd0);
        chk("reset rd", {27'd0, bus.reg_waddr_o}, 32'd0);

        // start_i with op_i[2]=0 is not a divide
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = 3'b000; bus.dividend_i = 32'd8; bus.divisor_i = 32'd2;
        @(negedge clk);
        chk("non-div busy", {31'd0, bus.busy_o}, 32'd0);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("non-div busy later", {31'd0, bus.busy_o}, 32'd0);
        @(posedge clk); #1;

        run("divu 100/7", DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34, -1);
        run("div -100/7", DIV, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFF2, 34, -1);
        run("rem -100/7", REM, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFFE, 34, -1);
        run("rem 100/-7", REM, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'd2, 34, -1);
        run("divu max/2", DIVU, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'h7FFF_FFFF, 34, -1);
        run("divu 5/0", DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 2, -1);
        run("remu 5/0", REMU, 32'd5, 32'd0, 5'd11, 32'd5, 2, -1);
        run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2, -1);
        run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 2, -1);

        // start_i mid-divide is ignored
        run("divu pulse", DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34, 10);

        // reset mid-divide
        begin
            int rdy_seen;
            rdy_seen = 0;
            bus.start_i = 1'b1; bus.op_i = DIVU; bus.dividend_i = 32'd100;
            bus.divisor_i = 32'd7; bus.reg_waddr_i = 5'd4;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (bus.ready_o) rdy_seen++;
                if (c == 13) chk("rst idle", {31'd0, bus.busy_o}, 32'd0);
                @(posedge clk); #1;
                bus.start_i = 1'b0;
                rst = (c + 1 == 12);
            end
            chk("rst no ready", rdy_seen, 32'd0);
            chk("rst result", bus.result_o, 32'd0);
            chk("rst rd", {27'd0, bus.reg_waddr_o}, 32'd0);
        end

        // back-to-back
        run("b2b divu 9/3", DIVU, 32'd9, 32'd3, 5'd1, 32'd3, 34, -1);
        run("b2b remu 9/4", REMU, 32'd9, 32'd4, 5'd2, 32'd1, 34, -1);
        @(negedge clk);
        chk("b2b ready after", {31'd0, bus.ready_o}, 32'd0);
        chk("b2b busy after", {31'd0, bus.busy_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
